control_sequencer: RTL

//  Hardwired control unit that produces the datapath control strobes (bus-source selects, register

---
 rtl/control_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for register-register ALU instructions.
// All strobes are registered and decoded from the next state, so each is valid for the whole cycle.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [4:0]  OP_NEG   = 5'b10001,
  parameter logic [4:0]  OP_NOT   = 5'b10010,
  parameter logic [4:0]  OP_NOP   = 5'b11010,
  parameter logic [4:0]  OP_HALT  = 5'b11011
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic [15:0] reg_out_sel,
  output logic [15:0] reg_in_en,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        read,
  output logic [4:0]  alu_instruction,
  output logic        done,
  output logic        illegal,
  output logic        halted
);

  // state  | meaning
  // IDLE   | waiting for run
  // T0     | PC -> MAR, Z <= PC+1
  // T1     | Z_LO -> PC, memory read into MDR (held MEM_WAIT+1 cycles)
  // T2     | MDR -> IR
  // T3..T5 | execute steps, length depends on opcode class
  // HALT   | parked until clear
  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  typedef struct packed {
    logic        pc_sel;
    logic        zlo_sel;
    logic        mdr_sel;
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic        pc_en;
    logic        pc_inc;
    logic        ir_en;
    logic        y_en;
    logic        z_en;
    logic        mar_en;
    logic        mdr_en;
    logic        rd;
    logic [4:0]  alu;
    logic        done;
    logic        ill;
    logic        hlt;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [16:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_3op, is_un;
  logic       unused_ir;

  assign unused_ir = ^IR_Data[14:0];

  // Decode from ir_d so the T3 strobes can use the IR value captured on the same edge.
  assign op     = ir_d[16:12];
  assign ra     = ir_d[11:8];
  assign rb     = ir_d[7:4];
  assign rc     = ir_d[3:0];
  assign is_3op = (op < 5'b01100);
  assign is_un  = (op == OP_NEG) || (op == OP_NOT);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = 3'(MEM_WAIT);
      end
      S_T1: begin
        if (wait_q == 3'd0) state_d = S_T2;
        else                wait_d  = wait_q - 3'd1;
      end
      S_T2: begin
        state_d = S_T3;
        ir_d    = IR_Data[31:15];
      end
      S_T3: begin
        if (is_3op || is_un)   state_d = S_T4;
        else if (op == OP_HALT) state_d = S_HALT;
        else                   state_d = S_T0;
      end
      S_T4:    state_d = is_3op ? S_T5 : S_T0;
      S_T5:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_T0: begin
        ctrl_d.pc_sel = 1'b1;
        ctrl_d.mar_en = 1'b1;
        ctrl_d.pc_inc = 1'b1;
        ctrl_d.z_en   = 1'b1;
      end
      S_T1: begin
        ctrl_d.zlo_sel = 1'b1;
        ctrl_d.pc_en   = 1'b1;
        ctrl_d.rd      = 1'b1;
        ctrl_d.mdr_en  = 1'b1;
      end
      S_T2: begin
        ctrl_d.mdr_sel = 1'b1;
        ctrl_d.ir_en   = 1'b1;
      end
      S_T3: begin
        if (is_3op) begin
          ctrl_d.reg_out = 16'd1 << rb;
          ctrl_d.y_en    = 1'b1;
        end else if (is_un) begin
          ctrl_d.reg_out = 16'd1 << rb;
          ctrl_d.alu     = op;
          ctrl_d.z_en    = 1'b1;
        end else if (op == OP_NOP) begin
          ctrl_d.done = 1'b1;
        end else if (op != OP_HALT) begin
          ctrl_d.ill  = 1'b1;
          ctrl_d.done = 1'b1;
        end
      end
      S_T4: begin
        if (is_3op) begin
          ctrl_d.reg_out = 16'd1 << rc;
          ctrl_d.alu     = op;
          ctrl_d.z_en    = 1'b1;
        end else begin
          ctrl_d.zlo_sel = 1'b1;
          ctrl_d.reg_in  = 16'd1 << ra;
          ctrl_d.done    = 1'b1;
        end
      end
      S_T5: begin
        ctrl_d.zlo_sel = 1'b1;
        ctrl_d.reg_in  = 16'd1 << ra;
        ctrl_d.done    = 1'b1;
      end
      S_HALT:  ctrl_d.hlt = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign PC_select           = ctrl_q.pc_sel;
  assign Z_LO_select         = ctrl_q.zlo_sel;
  assign MDR_select          = ctrl_q.mdr_sel;
  assign reg_out_sel         = ctrl_q.reg_out;
  assign reg_in_en           = ctrl_q.reg_in;
  assign PC_enable           = ctrl_q.pc_en;
  assign PC_increment_enable = ctrl_q.pc_inc;
  assign IR_enable           = ctrl_q.ir_en;
  assign Y_enable            = ctrl_q.y_en;
  assign Z_enable            = ctrl_q.z_en;
  assign MAR_enable          = ctrl_q.mar_en;
  assign MDR_enable          = ctrl_q.mdr_en;
  assign read                = ctrl_q.rd;
  assign alu_instruction     = ctrl_q.alu;
  assign done                = ctrl_q.done;
  assign illegal             = ctrl_q.ill;
  assign halted              = ctrl_q.hlt;

endmodule
